// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_pkg
// Purpose  : Shared FSM state type and constants for the APB master bridge.
// Revision : 1.0
// ============================================================================
package apb_pkg;

  localparam int APB_AW       = 12;
  localparam int APB_TO_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

endpackage
`default_nettype wire

// File: rtl/apb_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module   : apb_timeout_counter
// Purpose  : Counts unanswered ACCESS cycles and flags an APB completer timeout.
// Revision : 1.0
// ============================================================================
module apb_timeout_counter
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic pclk,
  input  logic presetn,
  input  logic clear,
  input  logic active,
  input  logic pready,
  output logic timeout
);

  localparam logic [APB_TO_CNT_W-1:0] c_last_count = APB_TO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [APB_TO_CNT_W-1:0] r_count;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (active && !pready) begin
      r_count <= r_count + APB_TO_CNT_W'(1);
    end
  end

  // Fires in the cycle whose unanswered wait would bring the count to the limit.
  assign timeout = active & ~pready & (r_count == c_last_count);

endmodule
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_bridge
// Purpose  : Single-outstanding command/response to APB requester bridge.
//            Optional ACCESS timeout enabled by APB_MASTER_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int D_WIDTH        = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 pclk,
  input  logic                 presetn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [APB_AW-1:0]    req_addr,
  input  logic [D_WIDTH-1:0]   req_wdata,
  input  logic [D_WIDTH/8-1:0] req_strb,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [D_WIDTH-1:0]   rsp_rdata,
  output logic                 rsp_error,
  output logic [APB_AW-1:0]    paddr,
  output logic                 psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [D_WIDTH-1:0]   pwdata,
  output logic [D_WIDTH/8-1:0] pstrb,
  input  logic [D_WIDTH-1:0]   prdata,
  input  logic                 pready,
  input  logic                 pslverr
);

  apb_state_e r_state;
  apb_state_e w_next_state;

  logic                 w_accept;
  logic                 w_timeout;
  logic                 w_req_ready;
  logic                 w_rsp_valid;
  logic [D_WIDTH-1:0]   w_rsp_rdata;
  logic                 w_rsp_error;
  logic [APB_AW-1:0]    w_paddr;
  logic                 w_psel;
  logic                 w_penable;
  logic                 w_pwrite;
  logic [D_WIDTH-1:0]   w_pwdata;
  logic [D_WIDTH/8-1:0] w_pstrb;

  // req_ready is only high in IDLE, so this is the command handshake.
  assign w_accept = req_valid & req_ready;

`ifdef APB_MASTER_TIMEOUT_EN
  apb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .pclk   (pclk),
    .presetn(presetn),
    .clear  (r_state == ST_SETUP),
    .active (r_state == ST_ACCESS),
    .pready (pready),
    .timeout(w_timeout)
  );
`else
  logic [7:0] w_unused_timeout_cycles;
  assign w_unused_timeout_cycles = 8'(TIMEOUT_CYCLES);
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state   <= ST_IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
      paddr     <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      pstrb     <= '0;
    end else begin
      r_state   <= w_next_state;
      req_ready <= w_req_ready;
      rsp_valid <= w_rsp_valid;
      rsp_rdata <= w_rsp_rdata;
      rsp_error <= w_rsp_error;
      paddr     <= w_paddr;
      psel      <= w_psel;
      penable   <= w_penable;
      pwrite    <= w_pwrite;
      pwdata    <= w_pwdata;
      pstrb     <= w_pstrb;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next_state = ST_SETUP;
      ST_SETUP:  w_next_state = ST_ACCESS;
      ST_ACCESS: if (pready || w_timeout) w_next_state = ST_RESP;
      ST_RESP:   if (rsp_ready) w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port leaves a flop.
  always_comb begin
    w_req_ready = (w_next_state == ST_IDLE);
    w_psel      = (w_next_state == ST_SETUP) || (w_next_state == ST_ACCESS);
    w_penable   = (w_next_state == ST_ACCESS);
    w_rsp_valid = (w_next_state == ST_RESP);
    w_rsp_rdata = rsp_rdata;
    w_rsp_error = rsp_error;
    w_paddr     = paddr;
    w_pwrite    = pwrite;
    w_pwdata    = pwdata;
    w_pstrb     = pstrb;

    if (w_accept) begin
      w_paddr  = req_addr;
      w_pwrite = req_write;
      w_pwdata = req_write ? req_wdata : '0;
      w_pstrb  = req_write ? req_strb  : '0;
    end

    if ((r_state == ST_ACCESS) && pready) begin
      w_rsp_rdata = (pwrite || pslverr) ? '0 : prdata;
      w_rsp_error = pslverr;
    end else if ((r_state == ST_ACCESS) && w_timeout) begin
      w_rsp_rdata = '0;
      w_rsp_error = 1'b1;
    end else if ((r_state == ST_RESP) && rsp_ready) begin
      w_rsp_rdata = '0;
      w_rsp_error = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master_bridge
// Purpose  : Scoreboard bench for apb_master_bridge with an APB completer model.
// Revision : 1.0
// ============================================================================
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int DW = 32;
  localparam int SW = DW / 8;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
  localparam int TOC   = 4;
`else
  localparam bit TO_EN = 1'b0;
  localparam int TOC   = 255;
`endif

  logic              pclk      = 1'b0;
  logic              presetn   = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [APB_AW-1:0] req_addr  = '0;
  logic [DW-1:0]     req_wdata = '0;
  logic [SW-1:0]     req_strb  = '0;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_error;
  logic [APB_AW-1:0] paddr;
  logic              psel, penable, pwrite;
  logic [DW-1:0]     pwdata;
  logic [SW-1:0]     pstrb;
  logic [DW-1:0]     prdata;
  logic              pready, pslverr;

  always #5 pclk = ~pclk;

  apb_master_bridge #(.D_WIDTH(DW), .TIMEOUT_CYCLES(TOC)) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  typedef struct {
    logic              write;
    logic [APB_AW-1:0] addr;
    logic [DW-1:0]     wdata;
    logic [SW-1:0]     strb;
    int                waits;
    logic [DW-1:0]     prdata;
    logic              slverr;
  } plan_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          error;
    int            cyc;
  } exp_t;

  plan_t plan_q[$];
  exp_t  sb_q[$];
  int    checks   = 0;
  int    errors   = 0;
  int    cyc      = 0;
  int    rdy_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: response value and the cycle rsp_valid must first be seen.
  function automatic exp_t model(input plan_t p, input int acc_cyc);
    exp_t e;
    if (TO_EN && p.waits >= TOC) begin
      e.rdata = '0;
      e.error = 1'b1;
      e.cyc   = acc_cyc + 2 + TOC;
    end else begin
      e.rdata = (p.write || p.slverr) ? '0 : p.prdata;
      e.error = p.slverr;
      e.cyc   = acc_cyc + 3 + p.waits;
    end
    return e;
  endfunction

  function automatic plan_t mk(input logic w, input logic [APB_AW-1:0] a, input logic [DW-1:0] wd,
                               input logic [SW-1:0] s, input int wt, input logic [DW-1:0] rd,
                               input logic err);
    plan_t p;
    p.write = w; p.addr = a; p.wdata = wd; p.strb = s;
    p.waits = wt; p.prdata = rd; p.slverr = err;
    return p;
  endfunction

  function automatic plan_t rand_plan();
    int wt;
    wt = TO_EN ? int'($urandom_range(0, TOC + 1)) : int'($urandom_range(0, 3));
    return mk(1'($urandom), 12'($urandom), $urandom, 4'($urandom), wt, $urandom,
              ($urandom_range(0, 3) == 0));
  endfunction

  initial forever begin
    @(posedge pclk);
    cyc++;
  end

  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge pclk);
      #1;
      case (rdy_mode)
        0:       rsp_ready = 1'($urandom);
        1:       rsp_ready = 1'b1;
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  // APB completer: follows the plan of the transaction it sees in SETUP.
  initial begin
    plan_t cur;
    int    acc  = 0;
    bit    have = 1'b0;
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    forever begin
      @(negedge pclk);
      if (!presetn) begin
        have = 1'b0;
      end else if (psel && !penable) begin
        if (plan_q.size() == 0) begin
          chk("setup_unexpected", 1, 0);
          have = 1'b0;
        end else begin
          cur  = plan_q.pop_front();
          have = 1'b1;
          acc  = 0;
        end
      end
      if (presetn && psel && have) begin
        chk("paddr", paddr, cur.addr);
        chk("pwrite", pwrite, cur.write);
        chk("pwdata", pwdata, cur.write ? cur.wdata : '0);
        chk("pstrb", pstrb, cur.write ? cur.strb : '0);
      end
      if (presetn && psel && penable && have) begin
        acc++;
        if (acc == cur.waits + 1) begin
          pready = 1'b1; pslverr = cur.slverr; prdata = cur.prdata;
        end else begin
          pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom;
        end
      end else begin
        pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
      end
    end
  end

  // Monitor: pops an expectation at the first cycle of each response.
  initial begin
    exp_t e;
    bit   active = 1'b0;
    forever begin
      @(negedge pclk);
      if (!presetn) begin
        active = 1'b0;
      end else if (rsp_valid) begin
        if (!active) begin
          if (sb_q.size() == 0) begin
            chk("rsp_unexpected", 1, 0);
          end else begin
            e      = sb_q.pop_front();
            active = 1'b1;
            chk("rsp_latency", cyc, e.cyc);
          end
        end
        if (active) begin
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_error", rsp_error, e.error);
          chk("rsp_apb_idle", {psel, penable, req_ready}, 0);
        end
        if (rsp_ready) active = 1'b0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic issue(input plan_t p, output int acc_cyc);
    int n = 0;
    req_valid = 1'b1; req_write = p.write; req_addr = p.addr;
    req_wdata = p.wdata; req_strb = p.strb;
    acc_cyc = -1;
    while (acc_cyc < 0 && n < 200) begin
      @(negedge pclk);
      if (req_ready) begin
        acc_cyc = cyc;
        plan_q.push_back(p);
        sb_q.push_back(model(p, cyc));
      end
      n++;
      @(posedge pclk);
      #1;
    end
    if (acc_cyc < 0) chk("req_accept_timeout", 0, 1);
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = 12'($urandom);
    req_wdata = $urandom; req_strb = 4'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge pclk);
      n++;
    end while (!(req_ready && sb_q.size() == 0) && n < 100);
    if (n >= 100) chk("idle_timeout", 0, 1);
    @(posedge pclk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctl"}, {req_ready, rsp_valid, rsp_error, psel, penable, pwrite, paddr, pstrb}, 0);
    chk({tag, "_data"}, {rsp_rdata, pwdata}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int    a, a_prev, n;
    plan_t p;

    repeat (3) @(posedge pclk);
    #1;
    chk_reset_vals("reset");
    presetn = 1'b1;
    @(negedge pclk);
    chk("req_ready_before_edge", req_ready, 0);
    @(posedge pclk);
    #1;
    chk("req_ready_after_edge", req_ready, 1);

    // Zero-wait write with explicit phase checks.
    rdy_mode = 1;
    issue(mk(1'b1, 12'h0A4, 32'hDEADBEEF, 4'hF, 0, 32'h0BAD0BAD, 1'b0), a);
    chk("setup_phase", {psel, penable, req_ready}, 3'b100);
    @(posedge pclk);
    #1;
    chk("access_phase", {psel, penable, req_ready}, 3'b110);
    wait_idle();

    issue(mk(1'b0, 12'h010, 32'hCAFEF00D, 4'hF, 3, 32'h12345678, 1'b0), a);
    wait_idle();
    issue(mk(1'b0, 12'h020, 32'h0, 4'h0, 1, 32'hFFFFFFFF, 1'b1), a);
    wait_idle();

    // Response back-pressure: held response, new command refused.
    rdy_mode = 2;
    issue(mk(1'b0, 12'h030, 32'h0, 4'h0, 0, 32'hA5A55A5A, 1'b0), a);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge pclk);
      n++;
    end
    chk("hold_rsp_seen", rsp_valid, 1);
    @(posedge pclk);
    #1;
    p = mk(1'b1, 12'h044, 32'h11223344, 4'h5, 0, 32'h0, 1'b0);
    req_valid = 1'b1; req_write = p.write; req_addr = p.addr;
    req_wdata = p.wdata; req_strb = p.strb;
    repeat (5) begin
      @(negedge pclk);
      chk("hold_refuse", {req_ready, psel, rsp_valid}, 3'b001);
    end
    rdy_mode = 1;
    issue(p, a);
    wait_idle();

    // Reset in the middle of ACCESS.
    issue(mk(1'b0, 12'h050, 32'h0, 4'h0, 5, 32'h55555555, 1'b0), a);
    @(posedge pclk);
    #1;
    @(posedge pclk);
    #3;
    presetn = 1'b0;
    #1;
    chk("abort_outputs", {psel, penable, rsp_valid, req_ready}, 0);
    sb_q.delete();
    plan_q.delete();
    @(posedge pclk);
    #1;
    chk_reset_vals("abort");
    presetn = 1'b1;
    wait_idle();

    if (TO_EN) begin
      issue(mk(1'b0, 12'h060, 32'h0, 4'h0, 40, 32'h77777777, 1'b0), a);
      wait_idle();
      issue(mk(1'b0, 12'h064, 32'h0, 4'h0, TOC - 1, 32'h87654321, 1'b0), a);
      wait_idle();
    end

    rdy_mode = 0;
    for (int i = 0; i < 40; i++) begin
      issue(rand_plan(), a);
      repeat ($urandom_range(0, 2)) begin
        @(posedge pclk);
        #1;
      end
    end
    rdy_mode = 1;
    wait_idle();

    // Back-to-back throughput with zero-wait completer.
    a_prev = -1;
    for (int i = 0; i < 5; i++) begin
      p = rand_plan();
      p.waits = 0;
      issue(p, a);
      if (a_prev >= 0) chk("b2b_spacing", a - a_prev, 4);
      a_prev = a;
    end
    wait_idle();
    repeat (3) @(posedge pclk);
    #1;
    chk("sb_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 SHALL have parameter D_WIDTH, default 32, APB data width in bits (8, 16 or 32).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, max ACCESS-phase wait cycles (1..255).
REQ-003 SHALL have port pclk  input  1  clock; all logic rises on posedge.
REQ-004 SHALL have port presetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  command request present.
REQ-006 SHALL have port req_ready  output  1  bridge accepts command this cycle.
REQ-007 SHALL have port req_write  input  1  1=write, 0=read.
REQ-008 SHALL have port req_addr  input  12  target byte address.
REQ-009 SHALL have port req_wdata  input  D_WIDTH  write data.
REQ-010 SHALL have port req_strb  input  D_WIDTH/8  write byte strobes.
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  response consumed.
REQ-013 SHALL have port rsp_rdata  output  D_WIDTH  read data; 0 for writes and errors.
REQ-014 SHALL have port rsp_error  output  1  slave error or timeout.
REQ-015 SHALL have ports paddr(12), psel(1), penable(1), pwrite(1), pwdata(D_WIDTH), pstrb(D_WIDTH/8), all outputs, APB requester side.
REQ-016 SHALL have ports prdata(D_WIDTH), pready(1), pslverr(1), all inputs, APB completer side.

Function
REQ-017 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP; all outputs registered.
REQ-018 IDLE: req_ready=1; req_valid&req_ready captures addr/write/wdata/strb, next SETUP.
REQ-019 SETUP: psel=1, penable=0, paddr/pwrite/pwdata/pstrb from captured command; next ACCESS unconditionally.
REQ-020 ACCESS: psel=1, penable=1, all APB signals stable; on pready=1 capture response, next RESP.
REQ-021 Read completion: rsp_rdata=prdata unless pslverr=1, then rsp_rdata=0; rsp_error=pslverr.
REQ-022 Write completion: rsp_rdata=0, rsp_error=pslverr.
REQ-023 pstrb SHALL be all-zero for reads; pwdata SHALL be 0 for reads.
REQ-024 RESP: rsp_valid=1, psel=0, penable=0; rsp_rdata/rsp_error held until rsp_valid&rsp_ready, then IDLE.
REQ-025 req_ready SHALL be 0 in SETUP, ACCESS, RESP; at most one transaction outstanding.
REQ-026 Latency: command accepted at edge N -> SETUP N+1, ACCESS N+2, zero-wait pready -> rsp_valid at N+3.
REQ-027 pready and pslverr SHALL be ignored outside ACCESS.
REQ-028 Back-to-back: with rsp_ready tied 1, minimum 4 cycles per transaction.

Reset
REQ-029 presetn low SHALL force IDLE immediately, mid-transaction included; no response issued for the aborted command.
REQ-030 Reset values: req_ready=0, then 1 from the first clock edge after release; rsp_valid=0, rsp_rdata=0, rsp_error=0, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, pstrb=0.

Configuration
REQ-031 Macro APB_MASTER_TIMEOUT_EN defined: 8-bit counter clears on ACCESS entry, increments each ACCESS cycle with pready=0.
REQ-032 With APB_MASTER_TIMEOUT_EN, when the count reaches TIMEOUT_CYCLES with pready=0, the bridge SHALL drop psel/penable and go to RESP with rsp_error=1, rsp_rdata=0.
REQ-033 pready=1 on the same cycle the count reaches TIMEOUT_CYCLES SHALL complete normally, with no timeout.
REQ-034 Without APB_MASTER_TIMEOUT_EN: ACCESS waits indefinitely for pready; no counter logic.

Structure
REQ-035 Package apb_pkg SHALL hold the FSM state enum, APB_AW=12 and the timeout counter width constant.
REQ-036 Sub-module apb_timeout_counter SHALL implement REQ-031..REQ-033 and is instantiated only under APB_MASTER_TIMEOUT_EN.

Verification
REQ-037 Write 0x0A4 data 0xDEADBEEF strb 0xF, pready=1 immediately -> SETUP then ACCESS, rsp_valid at N+3, rsp_error=0, rsp_rdata=0.
REQ-038 Read 0x010, pready after 3 wait cycles, prdata=0x12345678 -> APB signals stable for 4 ACCESS cycles, rsp_rdata=0x12345678.
REQ-039 Read with pslverr=1 at pready, prdata=0xFFFFFFFF -> rsp_error=1, rsp_rdata=0; read pstrb=0 throughout.
REQ-040 rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0, psel=0; new req_valid not accepted.
REQ-041 presetn low during ACCESS -> psel=penable=rsp_valid=0 asynchronously, IDLE after release, no response.
REQ-042 With APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4, pready stuck 0 -> 4 ACCESS cycles, then rsp_error=1; pready=1 on the 4th cycle -> normal completion.
